z80_mem_mapper: RTL

Parametrised memory mapper and bus-control block for the Z80 microcomputer. It sits between the CPU address bus and the external SRAM. It translates the 16-bit CPU address into a wider physical SRAM address through I/O-programmable page registers, and owns the boot-ROM overlay latch, which can now be re-armed by software. It also generates programmable wait states for slow pages.

---
 rtl/z80_mem_mapper.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/z80_mem_mapper.sv
// z80_mem_mapper: Z80 page mapper, boot-ROM overlay latch and wait-state generator.
// Ports: clk, n_reset, cpuAddress/cpuDataOut/n_ioWR/n_ioRD/n_MREQ in;
//        physAddress, n_mapperCS, mapDataOut, n_romActive, n_wait out.
module z80_mem_mapper #(
    parameter int PAGE_BITS = 2,
    parameter int PHYS_AW = 19,
    parameter logic [7:0] MAP_BASE = 8'h78,
    parameter logic [7:0] ROM_PORT = 8'h38,
    parameter int WAIT_CYCLES = 0,
    parameter int SLOW_PAGE_MASK = 0
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic [15:0]        cpuAddress,
    input  logic [7:0]         cpuDataOut,
    input  logic               n_ioWR,
    input  logic               n_ioRD,
    input  logic               n_MREQ,
    output logic [PHYS_AW-1:0] physAddress,
    output logic               n_mapperCS,
    output logic [7:0]         mapDataOut,
    output logic               n_romActive,
    output logic               n_wait
);

    localparam int NUM_PAGES = 2 ** PAGE_BITS;
    localparam int PRW = PHYS_AW - 16 + PAGE_BITS;
    localparam int OFFW = 16 - PAGE_BITS;
    localparam logic [NUM_PAGES-1:0] SLOW = NUM_PAGES'(SLOW_PAGE_MASK);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam logic [7:0] CTRL_OFS = 8'(NUM_PAGES);

    typedef enum logic [1:0] {IDLE, WAIT, HOLD} waitState_t;

    logic [PRW-1:0] pageReg [NUM_PAGES];
    logic mapEn;

    logic [PAGE_BITS-1:0] pg;
    logic [7:0] ioOfs;
    logic [PAGE_BITS-1:0] ioIdx;
    logic isPage;
    logic isCtrl;
    logic isRom;

    logic [2:0] wrSync;
    logic [2:0] mreqSync;
    logic wrCommit;
    logic mreqFall;
    logic mreqHigh;

    waitState_t state;
    logic [3:0] waitCnt;

    logic unusedData;
    assign unusedData = ^cpuDataOut;

    assign pg = cpuAddress[15 -: PAGE_BITS];
    // Addresses below MAP_BASE wrap to large offsets and fall out of range.
    assign ioOfs = cpuAddress[7:0] - MAP_BASE;
    assign ioIdx = ioOfs[PAGE_BITS-1:0];
    assign isPage = ioOfs < CTRL_OFS;
    assign isCtrl = ioOfs == CTRL_OFS;
    assign isRom = cpuAddress[7:0] == ROM_PORT;

    always_comb begin
        if (mapEn)
            physAddress = {pageReg[pg], cpuAddress[OFFW-1:0]};
        else
            physAddress = PHYS_AW'(cpuAddress);
    end

    always_comb begin
        n_mapperCS = 1'b1;
        mapDataOut = 8'hFF;
        if (!n_ioRD && (isPage || isCtrl)) begin
            n_mapperCS = 1'b0;
            if (isCtrl)
                mapDataOut = {7'b0, mapEn};
            else
                mapDataOut = 8'(pageReg[ioIdx]);
        end
    end

    // Sync flops reset low so a strobe held across reset release
    // never looks like a fresh falling edge.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wrSync <= 3'b000;
            mreqSync <= 3'b000;
        end else begin
            wrSync <= {wrSync[1:0], n_ioWR};
            mreqSync <= {mreqSync[1:0], n_MREQ};
        end
    end

    assign wrCommit = wrSync[2] & ~wrSync[1];
    assign mreqFall = mreqSync[2] & ~mreqSync[1];
    assign mreqHigh = mreqSync[1];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            for (int i = 0; i < NUM_PAGES; i++)
                pageReg[i] <= PRW'(i);
            mapEn <= 1'b0;
            n_romActive <= 1'b0;
        end else if (wrCommit) begin
            unique case (1'b1)
                isPage: pageReg[ioIdx] <= cpuDataOut[PRW-1:0];
                isCtrl: begin
                    mapEn <= cpuDataOut[0];
                    if (cpuDataOut[1])
                        n_romActive <= 1'b0;
                end
                isRom: n_romActive <= 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state <= IDLE;
            waitCnt <= 4'd0;
            n_wait <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (mreqFall && SLOW[pg] && (WAIT_LOAD != 4'd0)) begin
                        state <= WAIT;
                        waitCnt <= WAIT_LOAD;
                        n_wait <= 1'b0;
                    end
                end
                WAIT: begin
                    waitCnt <= waitCnt - 4'd1;
                    if (mreqHigh) begin
                        state <= IDLE;
                        n_wait <= 1'b1;
                    end else if (waitCnt == 4'd1) begin
                        state <= HOLD;
                        n_wait <= 1'b1;
                    end
                end
                HOLD: begin
                    if (mreqHigh)
                        state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    n_wait <= 1'b1;
                end
            endcase
        end
    end

endmodule
